// File: rtl/io_timer_pkg.sv
// Shared definitions for the IO timer: device number, register map,
// CTRL bit positions, FSM state encoding and a byte-mask merge helper.
package io_timer_pkg;

  localparam logic [7:0] TIMER_DEV = 8'h02;

  localparam logic [1:0] REG_CTRL     = 2'd0;
  localparam logic [1:0] REG_PRESCALE = 2'd1;
  localparam logic [1:0] REG_COMPARE  = 2'd2;
  localparam logic [1:0] REG_COUNT    = 2'd3;

  localparam int CTRL_EN       = 0;
  localparam int CTRL_PERIODIC = 1;
  localparam int CTRL_IRQ_EN   = 2;
  localparam int CTRL_PENDING  = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } timer_state_t;

  // Merge new data into an old word, one byte per mask bit.
  function automatic logic [31:0] apply_wmask(input logic [31:0] old_val,
                                              input logic [31:0] new_val,
                                              input logic [3:0]  mask);
    logic [31:0] merged;
    merged = old_val;
    for (int b = 0; b < 4; b++) begin
      if (mask[b]) merged[b*8 +: 8] = new_val[b*8 +: 8];
    end
    return merged;
  endfunction

endpackage

// File: rtl/timer_prescaler.sv
// Prescaler for the IO timer: counts up while running and emits a tick
// on the cycle it reaches the limit, wrapping back to zero on that edge.
module timer_prescaler #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             run,
  input  logic [WIDTH-1:0] limit,
  output logic             tick
);

  logic [WIDTH-1:0] cnt;

  // Using >= makes a limit lowered below the current count wrap next cycle.
  assign tick = run && (cnt >= limit);

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt <= '0;
    end else if (!run || tick) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + 1'b1;
    end
  end

endmodule

// File: rtl/io_timer.sv
// IO-space countdown timer: register file, run/expiry FSM and registered
// read mux, driving a level interrupt from PENDING & IRQ_EN.
module io_timer
  import io_timer_pkg::*;
#(
  parameter int PRESCALE_WIDTH = 16
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        cs,
  input  logic [3:0]  addr,
  input  logic [3:0]  wmask,
  input  logic [31:0] wdata,
  input  logic        rd_strobe,
  output logic [31:0] rdata,
  output logic        irq
);

  timer_state_t state_q, state_d;

  logic                      periodic_q;
  logic                      irq_en_q;
  logic                      pending_q;
  logic [PRESCALE_WIDTH-1:0] prescale_q;
  logic [PRESCALE_WIDTH-1:0] prescale_d;
  logic [31:0]               compare_q;
  logic [31:0]               count_q;
  logic [31:0]               rd_mux;
  logic [31:0]               prescale_ext;
  logic                      tick;
  logic                      running;
  logic                      unused_addr_bits;

  logic [1:0] reg_sel;
  logic       wr;
  logic       ctrl_wr;
  logic       en_byte_wr;
  logic       start;
  logic       stop;
  logic       expire;

  assign unused_addr_bits = ^addr[1:0];

  assign reg_sel    = addr[3:2];
  assign wr         = cs && (wmask != 4'b0000);
  assign ctrl_wr    = wr && (reg_sel == REG_CTRL);
  assign en_byte_wr = ctrl_wr && wmask[0];
  assign start      = en_byte_wr && wdata[CTRL_EN] && (state_q != RUN);
  assign stop       = en_byte_wr && !wdata[CTRL_EN] && (state_q != IDLE);
  assign running    = (state_q == RUN);
  assign expire     = tick && (count_q == 32'd0);

  timer_prescaler #(
    .WIDTH(PRESCALE_WIDTH)
  ) u_prescaler (
    .clk  (clk),
    .reset(reset),
    .run  (running),
    .limit(prescale_q),
    .tick (tick)
  );

  always_ff @(posedge clk) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  // A software stop outranks an expiry arriving on the same edge.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: if (start) state_d = RUN;
      RUN: begin
        if (stop)                     state_d = IDLE;
        else if (expire && !periodic_q) state_d = DONE;
      end
      DONE: begin
        if (start)     state_d = RUN;
        else if (stop) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    prescale_d = prescale_q;
    for (int i = 0; i < PRESCALE_WIDTH; i++) begin
      if (wmask[i[4:3]]) prescale_d[i] = wdata[i];
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      periodic_q <= 1'b0;
      irq_en_q   <= 1'b0;
      pending_q  <= 1'b0;
      prescale_q <= '0;
      compare_q  <= 32'd0;
      count_q    <= 32'd0;
      irq        <= 1'b0;
    end else begin
      irq <= pending_q && irq_en_q;
      if (en_byte_wr) begin
        periodic_q <= wdata[CTRL_PERIODIC];
        irq_en_q   <= wdata[CTRL_IRQ_EN];
      end
      if (expire)
        pending_q <= 1'b1;
      else if (ctrl_wr && wmask[1] && wdata[CTRL_PENDING])
        pending_q <= 1'b0;
      if (wr && reg_sel == REG_PRESCALE) prescale_q <= prescale_d;
      if (wr && reg_sel == REG_COMPARE)
        compare_q <= apply_wmask(compare_q, wdata, wmask);
      // A one-shot expiry leaves COUNT at zero; periodic reloads COMPARE.
      if (start) begin
        count_q <= compare_q;
      end else if (tick && !stop) begin
        if (count_q != 32'd0)  count_q <= count_q - 32'd1;
        else if (periodic_q)   count_q <= compare_q;
      end
    end
  end

  always_comb begin
    prescale_ext                     = 32'd0;
    prescale_ext[PRESCALE_WIDTH-1:0] = prescale_q;
    rd_mux = 32'd0;
    case (reg_sel)
      REG_CTRL: begin
        rd_mux[CTRL_EN]       = running;
        rd_mux[CTRL_PERIODIC] = periodic_q;
        rd_mux[CTRL_IRQ_EN]   = irq_en_q;
        rd_mux[CTRL_PENDING]  = pending_q;
      end
      REG_PRESCALE: rd_mux = prescale_ext;
      REG_COMPARE:  rd_mux = compare_q;
      REG_COUNT:    rd_mux = count_q;
      default:      rd_mux = 32'd0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset)                rdata <= 32'd0;
    else if (cs && rd_strobe) rdata <= rd_mux;
  end

endmodule
